// File: rtl/day2_pkg.sv
// Shared definitions for the day-2 range loader.
//   - ASCII byte constants recognised by the range parser
//   - loader_state_t : top-level sequencing states
//   - parse_state_t  : position inside a "start-end" range
//   - range_t        : one {start, end} pair at the default ID width
//   - is_digit       : ASCII '0'..'9' test
package day2_pkg;

  localparam int ID_W = 48;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    PARSE,
    LOAD,
    RUN,
    DRAIN,
    RESULT
  } loader_state_t;

  typedef enum logic {
    WANT_START,
    WANT_END
  } parse_state_t;

  typedef struct packed {
    logic [ID_W-1:0] start_id;
    logic [ID_W-1:0] end_id;
  } range_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/dec_accum.sv
// W-bit decimal accumulator: value <= value*10 + digit.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   clear_i         : zero the value and forget any digits (wins over a digit)
//   digit_valid_i   : fold digit_i into the value this cycle
//   digit_i         : binary digit 0..9
//   value_o         : current accumulated value
//   overflow_o      : folding digit_i into value_o would exceed W bits
//   nonempty_o      : at least one digit accepted since the last clear
module dec_accum
  import day2_pkg::*;
#(
  parameter int W = ID_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         digit_valid_i,
  input  logic [3:0]   digit_i,
  output logic [W-1:0] value_o,
  output logic         overflow_o,
  output logic         nonempty_o
);

  logic [W-1:0] value_q, value_d;
  logic         nonempty_q, nonempty_d;
  logic [W+3:0] ext, prod;

  // Four guard bits hold value*10+9 for any W-bit value, so overflow is
  // simply "any guard bit set". Independent of digit_valid_i so the parent
  // can use it to decide what to do with the digit without a comb loop.
  assign ext        = {4'b0000, value_q};
  assign prod       = (ext << 3) + (ext << 1) + {{W{1'b0}}, digit_i};
  assign overflow_o = (prod[W+3:W] != 4'b0000);

  always_comb begin
    value_d    = value_q;
    nonempty_d = nonempty_q;
    if (clear_i) begin
      value_d    = '0;
      nonempty_d = 1'b0;
    end else if (digit_valid_i && !overflow_o) begin
      value_d    = prod[W-1:0];
      nonempty_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q    <= '0;
      nonempty_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      nonempty_q <= nonempty_d;
    end
  end

  assign value_o    = value_q;
  assign nonempty_o = nonempty_q;

endmodule

// File: rtl/day2_range_loader.sv
// Front end for day2_puzzle: parses an ASCII "start-end,start-end\n" byte
// stream, packs up to NUM_UNITS ranges per batch, runs each batch on the
// puzzle core and returns the cumulative ID sum.
// Ports:
//   clock, reset_n              : clock, asynchronous active-low reset
//   in_data/in_valid/in_last    : input byte stream; in_ready accepts a byte
//   puz_reset/puz_load/puz_en   : control of day2_puzzle
//   puz_start_id/puz_end_id     : per-unit range slots
//   puz_id_sum/puz_done         : status from day2_puzzle
//   result/result_valid/_ready  : final sum, held until taken
//   busy                        : any state other than IDLE
//   error                       : sticky parse error for the current stream
module day2_range_loader
  import day2_pkg::*;
#(
  parameter int W         = ID_W,
  parameter int NUM_UNITS = 8,
  parameter int GUARD     = 6,
  parameter int SUM_LAT   = NUM_UNITS / 2 + NUM_UNITS % 2 + 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [7:0]                     in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic                           puz_reset,
  output logic                           puz_load,
  output logic                           puz_en,
  output logic [NUM_UNITS-1:0][W-1:0]    puz_start_id,
  output logic [NUM_UNITS-1:0][W-1:0]    puz_end_id,
  input  logic [W-1:0]                   puz_id_sum,
  input  logic                           puz_done,
  output logic [W-1:0]                   result,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic                           busy,
  output logic                           error
);

  localparam int IW = $clog2(NUM_UNITS + 1);
  localparam int CW = $clog2(GUARD + SUM_LAT + 1) + 1;

  // Empty-range pad (start=1, end=0): an idle unit finishes at once and adds 0.
  localparam logic [NUM_UNITS-1:0][W-1:0] PAD_START = {NUM_UNITS{W'(1)}};
  localparam logic [NUM_UNITS-1:0][W-1:0] PAD_END   = '0;

  loader_state_t                state_q, state_d;
  parse_state_t                 ps_q, ps_d;
  logic                         resync_q, resync_d;
  logic                         last_pend_q, last_pend_d;
  logic                         final_q, final_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [W-1:0]                 start_q, start_d;
  logic [NUM_UNITS-1:0][W-1:0]  slot_start_q, slot_start_d;
  logic [NUM_UNITS-1:0][W-1:0]  slot_end_q, slot_end_d;
  logic                         err_q, err_d;
  logic [W-1:0]                 result_q, result_d;
  logic [CW-1:0]                cnt_q, cnt_d;

  logic                         acc_clear, acc_dv, acc_ovf, acc_nonempty;
  logic [W-1:0]                 acc_value;
  logic                         consume, commit, is_sep;

  dec_accum #(.W(W)) u_acc (
    .clk_i         (clock),
    .rst_ni        (reset_n),
    .clear_i       (acc_clear),
    .digit_valid_i (acc_dv),
    .digit_i       (in_data[3:0]),
    .value_o       (acc_value),
    .overflow_o    (acc_ovf),
    .nonempty_o    (acc_nonempty)
  );

  // Intake pauses once the batch is full and for the one cycle after the
  // final byte, when a range still open at end of stream is committed.
  assign in_ready = (state_q == PARSE) && !last_pend_q && (idx_q != IW'(NUM_UNITS));
  assign consume  = in_valid && in_ready;
  assign is_sep   = (in_data == CH_COMMA) || (in_data == CH_LF);

  always_comb begin
    state_d      = state_q;
    ps_d         = ps_q;
    resync_d     = resync_q;
    last_pend_d  = last_pend_q;
    final_d      = final_q;
    idx_d        = idx_q;
    start_d      = start_q;
    slot_start_d = slot_start_q;
    slot_end_d   = slot_end_q;
    err_d        = err_q;
    result_d     = result_q;
    cnt_d        = cnt_q;
    acc_clear    = 1'b0;
    acc_dv       = 1'b0;
    commit       = 1'b0;

    unique case (state_q)
      IDLE: begin
        ps_d         = WANT_START;
        resync_d     = 1'b0;
        last_pend_d  = 1'b0;
        final_d      = 1'b0;
        idx_d        = '0;
        acc_clear    = 1'b1;
        slot_start_d = PAD_START;
        slot_end_d   = PAD_END;
        err_d        = 1'b0;
        if (in_valid) state_d = PARSE;
      end

      PARSE: begin
        if (last_pend_q) begin
          if (!resync_q && (ps_q == WANT_END) && acc_nonempty) commit = 1'b1;
          acc_clear   = 1'b1;
          ps_d        = WANT_START;
          resync_d    = 1'b0;
          last_pend_d = 1'b0;
          final_d     = 1'b1;
          cnt_d       = '0;
          state_d     = (commit || (idx_q != '0)) ? LOAD : DRAIN;
        end else if (idx_q == IW'(NUM_UNITS)) begin
          state_d = LOAD;
        end else if (consume) begin
          if (resync_q) begin
            // After an overflow everything up to the next separator belongs
            // to the discarded range.
            if (is_sep) begin
              resync_d  = 1'b0;
              acc_clear = 1'b1;
              ps_d      = WANT_START;
            end
          end else if (is_digit(in_data)) begin
            acc_dv = 1'b1;
            if (acc_ovf) begin
              err_d     = 1'b1;
              resync_d  = 1'b1;
              acc_clear = 1'b1;
              ps_d      = WANT_START;
            end
          end else if ((in_data == CH_SP) || (in_data == CH_CR)) begin
            // whitespace carries no meaning
          end else if ((in_data == CH_DASH) && (ps_q == WANT_START) && acc_nonempty) begin
            start_d   = acc_value;
            acc_clear = 1'b1;
            ps_d      = WANT_END;
          end else if (is_sep && (ps_q == WANT_END) && acc_nonempty) begin
            commit    = 1'b1;
            acc_clear = 1'b1;
            ps_d      = WANT_START;
          end else begin
            // Unknown byte, misplaced punctuation or an empty number.
            err_d     = 1'b1;
            acc_clear = 1'b1;
            ps_d      = WANT_START;
          end
          if (in_last) last_pend_d = 1'b1;
        end
      end

      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end

      RUN: begin
        // puz_done may still reflect the previous batch while the finder
        // pipeline refills, so it is ignored until the guard has run out.
        if (cnt_q < CW'(GUARD)) begin
          cnt_d = cnt_q + CW'(1);
        end else if (puz_done) begin
          if (final_q) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            slot_start_d = PAD_START;
            slot_end_d   = PAD_END;
            idx_d        = '0;
            state_d      = PARSE;
          end
        end
      end

      DRAIN: begin
        if (cnt_q == CW'(SUM_LAT - 1)) begin
          result_d = puz_id_sum;
          state_d  = RESULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RESULT: begin
        if (result_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (commit) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (idx_q == IW'(i)) begin
          slot_start_d[i] = start_q;
          slot_end_d[i]   = acc_value;
        end
      end
      idx_d = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ps_q         <= WANT_START;
      resync_q     <= 1'b0;
      last_pend_q  <= 1'b0;
      final_q      <= 1'b0;
      idx_q        <= '0;
      start_q      <= '0;
      slot_start_q <= PAD_START;
      slot_end_q   <= PAD_END;
      err_q        <= 1'b0;
      result_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ps_q         <= ps_d;
      resync_q     <= resync_d;
      last_pend_q  <= last_pend_d;
      final_q      <= final_d;
      idx_q        <= idx_d;
      start_q      <= start_d;
      slot_start_q <= slot_start_d;
      slot_end_q   <= slot_end_d;
      err_q        <= err_d;
      result_q     <= result_d;
      cnt_q        <= cnt_d;
    end
  end

  assign puz_reset    = (state_q == IDLE);
  assign puz_load     = (state_q == LOAD);
  assign puz_en       = (state_q == RUN);
  assign puz_start_id = slot_start_q;
  assign puz_end_id   = slot_end_q;
  assign result       = result_q;
  assign result_valid = (state_q == RESULT);
  assign busy         = (state_q != IDLE);
  assign error        = err_q;

endmodule

// File: tb/tb_day2_range_loader.sv
module tb_day2_range_loader;
  import day2_pkg::*;

  localparam int W  = 48;
  localparam int NU = 2;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  logic [7:0]             in_data = 8'h00;
  logic                   in_valid = 1'b0;
  logic                   in_last = 1'b0;
  logic                   in_ready;
  logic                   puz_reset, puz_load, puz_en;
  logic [NU-1:0][W-1:0]   puz_start_id, puz_end_id;
  logic [W-1:0]           puz_id_sum;
  logic                   puz_done;
  logic [W-1:0]           result;
  logic                   result_valid;
  logic                   result_ready = 1'b0;
  logic                   busy, error;

  int n_vec = 0;
  int n_bad = 0;

  day2_range_loader #(.W(W), .NUM_UNITS(NU)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .puz_reset    (puz_reset),
    .puz_load     (puz_load),
    .puz_en       (puz_en),
    .puz_start_id (puz_start_id),
    .puz_end_id   (puz_end_id),
    .puz_id_sum   (puz_id_sum),
    .puz_done     (puz_done),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .error        (error)
  );

  always #5 clock = ~clock;

  // An ID is invalid when its decimal digits are one block repeated >= 2 times.
  function automatic bit is_invalid(input longint unsigned n);
    int L;
    longint unsigned t, base, pat, rep;
    if (n < 10) return 1'b0;
    L = 0;
    t = n;
    while (t > 0) begin L++; t = t / 10; end
    for (int p = 1; p <= L / 2; p++) begin
      if (L % p == 0) begin
        base = 1;
        for (int k = 0; k < p; k++) base = base * 10;
        pat = n % base;
        rep = 0;
        for (int k = 0; k < L / p; k++) rep = rep * base + pat;
        if (rep == n) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic longint unsigned range_sum(input longint unsigned s, input longint unsigned e);
    longint unsigned acc;
    acc = 0;
    if (e >= s && (e - s) < 20000) begin
      for (longint unsigned v = s; v <= e; v++) if (is_invalid(v)) acc += v;
    end
    return acc;
  endfunction

  function automatic longint unsigned batch_sum(input logic [NU-1:0][W-1:0] s,
                                                input logic [NU-1:0][W-1:0] e);
    longint unsigned acc;
    acc = 0;
    for (int i = 0; i < NU; i++) acc += range_sum(64'(s[i]), 64'(e[i]));
    return acc;
  endfunction

  // Stand-in for day2_puzzle: cumulative sum, random finish time, and a
  // stale done level that lingers for a few enabled cycles after a load.
  logic [W-1:0] stub_sum, stub_pending, ld_s1, ld_e1;
  logic         stub_done;
  int           stub_remain, stub_stale;
  int           load_count = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stub_sum <= '0; stub_pending <= '0; stub_done <= 1'b1;
      stub_remain <= 0; stub_stale <= 0;
    end else if (puz_reset) begin
      stub_sum <= '0; stub_done <= 1'b1; stub_remain <= 0; stub_stale <= 0;
    end else if (puz_load) begin
      stub_pending <= W'(batch_sum(puz_start_id, puz_end_id));
      stub_remain  <= int'($urandom_range(0, 12));
      stub_stale   <= stub_done ? 3 : 0;
      stub_done    <= 1'b0;
      load_count   <= load_count + 1;
      ld_s1        <= puz_start_id[1];
      ld_e1        <= puz_end_id[1];
    end else if (puz_en) begin
      if (stub_stale != 0) stub_stale <= stub_stale - 1;
      if (!stub_done) begin
        if (stub_remain == 0) begin
          stub_sum  <= stub_sum + stub_pending;
          stub_done <= 1'b1;
        end else begin
          stub_remain <= stub_remain - 1;
        end
      end
    end
  end

  assign puz_done   = stub_done || (stub_stale != 0);
  assign puz_id_sum = stub_sum;

  task automatic send_stream(input string s, input bit gaps, output bit timed_out);
    int  t;
    bit  acc;
    timed_out = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          @(posedge clock); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = (i == s.len() - 1);
      acc = 1'b0;
      t   = 0;
      while (!acc) begin
        @(negedge clock);
        acc = in_ready;
        @(posedge clock); #1;
        t++;
        if (!acc && t > 5000) begin
          timed_out = 1'b1;
          in_valid = 1'b0; in_last = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect_result(input int hold, output bit got, output logic [W-1:0] res,
                                output logic err, output bit held, output logic busy_after,
                                output logic err_after);
    int t;
    got = 1'b0; held = 1'b1; t = 0;
    while (!got && t < 20000) begin
      @(negedge clock);
      if (result_valid === 1'b1) got = 1'b1;
      t++;
    end
    res = result;
    err = error;
    if (got) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clock);
        if (result_valid !== 1'b1 || result !== res) held = 1'b0;
      end
    end
    @(posedge clock); #1 result_ready = 1'b1;
    @(posedge clock); #1 result_ready = 1'b0;
    @(negedge clock);
    busy_after = busy;
    err_after  = error;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; result_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [NU-1:0][W-1:0] pad_s;
    pad_s = {NU{48'd1}};
    do_reset();
    @(negedge clock);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_vec++; if ({puz_reset, puz_load, puz_en} !== 3'b100) begin n_bad++; $display("FAIL reset_puz_ctl got %b want 100", {puz_reset, puz_load, puz_en}); end
    n_vec++; if (result_valid !== 1'b0 || result !== '0) begin n_bad++; $display("FAIL reset_result got v=%b r=%0d want v=0 r=0", result_valid, result); end
    n_vec++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error got %b want 0", error); end
    n_vec++; if (puz_start_id !== pad_s || puz_end_id !== '0) begin n_bad++; $display("FAIL reset_pad got s=%h e=%h want s=%h e=0", puz_start_id, puz_end_id, pad_s); end
  endtask

  task automatic test_single_batch();
    bit to, got, held; logic [W-1:0] res; logic err, ba, ea; int l0;
    l0 = load_count;
    send_stream("11-22,95-115\n", 1'b0, to);
    collect_result(0, got, res, err, held, ba, ea);
    n_vec++; if (to || !got) begin n_bad++; $display("FAIL single_timeout to=%b got=%b want 0/1", to, got); end
    n_vec++; if (res !== 48'd243) begin n_bad++; $display("FAIL single_sum got %0d want 243", res); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err got %b want 0", err); end
    n_vec++; if (load_count - l0 != 1) begin n_bad++; $display("FAIL single_loads got %0d want 1", load_count - l0); end
    n_vec++; if (ba !== 1'b0) begin n_bad++; $display("FAIL single_busy_after got %b want 0", ba); end
  endtask

  task automatic test_two_batches();
    bit to, got, held; logic [W-1:0] res; logic err, ba, ea; int l0;
    l0 = load_count;
    send_stream("11-22,95-115,998-1012", 1'b0, to);
    collect_result(0, got, res, err, held, ba, ea);
    n_vec++; if (to || !got) begin n_bad++; $display("FAIL two_timeout to=%b got=%b want 0/1", to, got); end
    n_vec++; if (res !== 48'd2252) begin n_bad++; $display("FAIL two_sum got %0d want 2252", res); end
    n_vec++; if (load_count - l0 != 2) begin n_bad++; $display("FAIL two_loads got %0d want 2", load_count - l0); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL two_err got %b want 0", err); end
  endtask

  task automatic test_parse_error();
    bit to, got, held; logic [W-1:0] res; logic err, ba, ea;
    send_stream("1-5,x7-9\n", 1'b0, to);
    collect_result(0, got, res, err, held, ba, ea);
    n_vec++; if (to || !got) begin n_bad++; $display("FAIL perr_timeout to=%b got=%b want 0/1", to, got); end
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL perr_err got %b want 1", err); end
    n_vec++; if (res !== '0) begin n_bad++; $display("FAIL perr_sum got %0d want 0", res); end
    n_vec++; if (ba !== 1'b0 || ea !== 1'b0) begin n_bad++; $display("FAIL perr_after got busy=%b err=%b want 0/0", ba, ea); end
  endtask

  task automatic test_overflow();
    bit to, got, held; logic [W-1:0] res; logic err, ba, ea;
    send_stream("999999999999999999999-5,33-44\n", 1'b0, to);
    collect_result(0, got, res, err, held, ba, ea);
    n_vec++; if (to || !got) begin n_bad++; $display("FAIL ovf_timeout to=%b got=%b want 0/1", to, got); end
    n_vec++; if (res !== 48'd77) begin n_bad++; $display("FAIL ovf_sum got %0d want 77", res); end
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovf_err got %b want 1", err); end
    n_vec++; if (ld_s1 !== 48'd1 || ld_e1 !== 48'd0) begin n_bad++; $display("FAIL ovf_pad got s=%0d e=%0d want 1/0", ld_s1, ld_e1); end
    send_stream("-5,12-13,33-44\n", 1'b1, to);
    collect_result(0, got, res, err, held, ba, ea);
    n_vec++; if (to || !got || res !== 48'd77 || err !== 1'b1) begin n_bad++; $display("FAIL empty_num got to=%b got=%b sum=%0d err=%b want 0/1/77/1", to, got, res, err); end
  endtask

  task automatic test_random_handshake();
    range_t rq[$];
    string s;
    bit to, got, held, bad_tok; logic [W-1:0] res; logic err, ba, ea;
    longint unsigned exp_sum;
    int k, a, b;
    for (int it = 0; it < 6; it++) begin
      rq.delete();
      s = "";
      bad_tok = 1'b0;
      k = int'($urandom_range(1, 5));
      for (int r = 0; r < k; r++) begin
        if ($urandom_range(0, 5) == 0) begin
          s = {s, "1234567890123456789012-7,"};
          bad_tok = 1'b1;
        end
        a = int'($urandom_range(1, 3000));
        b = a + int'($urandom_range(0, 150));
        rq.push_back('{start_id: ID_W'(a), end_id: ID_W'(b)});
        s = {s, $sformatf("%0d-%0d", a, b)};
        if (r != k - 1) begin
          case ($urandom_range(0, 2))
            0: s = {s, ","};
            1: s = {s, ", "};
            default: s = {s, "\r\n"};
          endcase
        end else if ($urandom_range(0, 1) == 1) begin
          s = {s, "\n"};
        end
      end
      exp_sum = 0;
      foreach (rq[j]) exp_sum += range_sum(64'(rq[j].start_id), 64'(rq[j].end_id));
      send_stream(s, 1'b1, to);
      collect_result(10, got, res, err, held, ba, ea);
      n_vec++; if (to || !got) begin n_bad++; $display("FAIL rand%0d_timeout to=%b got=%b want 0/1", it, to, got); end
      n_vec++; if (res !== W'(exp_sum)) begin n_bad++; $display("FAIL rand%0d_sum got %0d want %0d", it, res, exp_sum); end
      n_vec++; if (err !== bad_tok) begin n_bad++; $display("FAIL rand%0d_err got %b want %b", it, err, bad_tok); end
      n_vec++; if (!held) begin n_bad++; $display("FAIL rand%0d_hold got unstable want stable", it); end
      n_vec++; if (ba !== 1'b0) begin n_bad++; $display("FAIL rand%0d_busy_after got %b want 0", it, ba); end
    end
  endtask

  task automatic test_reset_mid_run();
    bit to, got, held, saw; logic [W-1:0] res; logic err, ba, ea; int t;
    send_stream("11-22,95-115\n", 1'b0, to);
    saw = 1'b0; t = 0;
    while (!saw && t < 200) begin
      @(negedge clock);
      if (puz_en === 1'b1) saw = 1'b1;
      t++;
    end
    n_vec++; if (to || !saw) begin n_bad++; $display("FAIL midrst_run got to=%b en_seen=%b want 0/1", to, saw); end
    #1 reset_n = 1'b0;
    #1;
    n_vec++; if ({busy, puz_reset, puz_load, puz_en, result_valid} !== 5'b01000) begin n_bad++; $display("FAIL midrst_outputs got %b want 01000", {busy, puz_reset, puz_load, puz_en, result_valid}); end
    n_vec++; if (puz_end_id !== '0 || error !== 1'b0) begin n_bad++; $display("FAIL midrst_regs got end=%h err=%b want 0/0", puz_end_id, error); end
    @(posedge clock); #1 reset_n = 1'b1;
    send_stream("998-1012\n", 1'b1, to);
    collect_result(0, got, res, err, held, ba, ea);
    n_vec++; if (to || !got || res !== 48'd2009) begin n_bad++; $display("FAIL midrst_fresh got to=%b got=%b sum=%0d want 0/1/2009", to, got, res); end
  endtask

  initial begin
    test_reset();
    test_single_batch();
    test_two_batches();
    test_parse_error();
    test_overflow();
    test_random_handshake();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got no finish want finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
